// File: rtl/fp_wb_arbiter.sv
// FP write-back arbiter: merges FMA and buffered div/sqrt results onto the
// single f-register-file write port and tracks pending writes for issue.
module fp_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_issue_valid,
    input  logic        i_issue_wr,
    input  logic [4:0]  i_issue_rd_addr,
    input  logic [4:0]  i_issue_rs1_addr,
    input  logic [4:0]  i_issue_rs2_addr,
    input  logic [4:0]  i_issue_rs3_addr,
    input  logic        i_issue_uses_rs3,
    output logic        o_issue_stall,
    input  logic        i_fma_valid,
    input  logic [4:0]  i_fma_rd_addr,
    input  logic [31:0] i_fma_data,
    input  logic        i_div_valid,
    input  logic [4:0]  i_div_rd_addr,
    input  logic [31:0] i_div_data,
    output logic        o_div_ready,
    output logic        o_rd_wren,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_mem_addr [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_busy;
    logic          r_rd_wren;
    logic [4:0]    r_rd_addr;
    logic [31:0]   r_rd_data;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_win;
    logic [4:0]    w_win_addr;
    logic [31:0]   w_win_data;
    logic          w_starved;
    logic          w_accept;
    logic [31:0]   w_busy_nxt;

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign o_div_ready = !w_full & i_rst_n;
    assign w_push      = i_div_valid & o_div_ready;
    // FMA has no backpressure, so the FIFO head only goes when FMA is idle
    assign w_pop       = !i_fma_valid & !w_empty;
    assign w_win       = i_fma_valid | w_pop;
    assign w_win_addr  = i_fma_valid ? i_fma_rd_addr : r_mem_addr[r_rptr];
    assign w_win_data  = i_fma_valid ? i_fma_data : r_mem_data[r_rptr];
    assign w_starved   = (r_starve == SW'(STARVE_MAX));

    // Issue hold: operand/destination hazards or a starved div FIFO
    always_comb begin
        o_issue_stall = r_busy[i_issue_rs1_addr]
                      | r_busy[i_issue_rs2_addr]
                      | (i_issue_uses_rs3 & r_busy[i_issue_rs3_addr])
                      | (i_issue_wr & r_busy[i_issue_rd_addr])
                      | w_starved;
    end

    assign w_accept = i_issue_valid & !o_issue_stall;

    // Next scoreboard: set on accepted writer, clear on write-back (clear wins)
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_accept && i_issue_wr && (i_issue_rd_addr != 5'd0)) begin
            w_busy_nxt[i_issue_rd_addr] = 1'b1;
        end
        if (w_win) begin
            w_busy_nxt[w_win_addr] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= i_div_rd_addr;
            r_mem_data[r_wptr] <= i_div_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap by power-of-two width
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Count cycles the waiting FIFO head loses to FMA, saturating
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_pop) begin
            r_starve <= '0;
        end else if (i_fma_valid && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    // Register the arbitration winner onto the register-file write port
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_wren <= 1'b0;
            r_rd_addr <= '0;
            r_rd_data <= '0;
        end else if (w_win) begin
            r_rd_wren <= (w_win_addr != 5'd0);
            r_rd_addr <= w_win_addr;
            r_rd_data <= w_win_data;
        end else begin
            r_rd_wren <= 1'b0;
        end
    end

    // Scoreboard register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rd_wren = r_rd_wren;
    assign o_rd_addr = r_rd_addr;
    assign o_rd_data = r_rd_data;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: queue-based reference model checked every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_fp_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic [4:0]  issue_rs3;
    logic        issue_uses_rs3;
    logic        issue_stall;
    logic        fma_valid;
    logic [4:0]  fma_rd;
    logic [31:0] fma_data;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_data;
    logic        div_ready;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy;

    fp_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_issue_valid   (issue_valid),
        .i_issue_wr      (issue_wr),
        .i_issue_rd_addr (issue_rd),
        .i_issue_rs1_addr(issue_rs1),
        .i_issue_rs2_addr(issue_rs2),
        .i_issue_rs3_addr(issue_rs3),
        .i_issue_uses_rs3(issue_uses_rs3),
        .o_issue_stall   (issue_stall),
        .i_fma_valid     (fma_valid),
        .i_fma_rd_addr   (fma_rd),
        .i_fma_data      (fma_data),
        .i_div_valid     (div_valid),
        .i_div_rd_addr   (div_rd),
        .i_div_data      (div_data),
        .o_div_ready     (div_ready),
        .o_rd_wren       (rd_wren),
        .o_rd_addr       (rd_addr),
        .o_rd_data       (rd_data),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: pending-write set, FIFO as a queue, loss counter
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_busy = '0;
    int          m_starve = 0;
    logic        m_wren = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    function automatic bit m_stall();
        return m_busy[issue_rs1] || m_busy[issue_rs2]
            || (issue_uses_rs3 && m_busy[issue_rs3])
            || (issue_wr && m_busy[issue_rd])
            || (m_starve >= STARVE_MAX);
    endfunction

    always @(posedge clk) begin
        int          n;
        bit          st;
        bit          win;
        logic [4:0]  wa;
        logic [31:0] wd;
        ent_t        e;
        if (!rst_n) begin
            m_q.delete();
            m_busy   = '0;
            m_starve = 0;
            m_wren   = 0;
            m_addr   = '0;
            m_data   = '0;
        end else begin
            n   = m_q.size();
            st  = m_stall();
            win = 0;
            wa  = '0;
            wd  = '0;
            if (fma_valid) begin
                win = 1; wa = fma_rd; wd = fma_data;
            end else if (n > 0) begin
                e = m_q.pop_front();
                win = 1; wa = e.a; wd = e.d;
            end
            if (div_valid && n < DEPTH) begin
                e.a = div_rd; e.d = div_data;
                m_q.push_back(e);
            end
            if (n == 0 || !fma_valid) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
            if (issue_valid && !st && issue_wr && issue_rd != 0)
                m_busy[issue_rd] = 1'b1;
            if (win) m_busy[wa] = 1'b0;
            m_busy[0] = 1'b0;
            if (win) begin
                m_wren = (wa != 0); m_addr = wa; m_data = wd;
            end else begin
                m_wren = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("wren", rd_wren, m_wren);
            if (m_wren) begin
                check("addr", rd_addr, m_addr);
                check("data", rd_data, m_data);
            end
            check("busy", busy, m_busy);
            check("div_ready", div_ready, rst_n && (m_q.size() < DEPTH));
            check("stall", issue_stall, m_stall());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        issue_valid = 0; issue_wr = 0; issue_rd = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rs3 = 0; issue_uses_rs3 = 0;
        fma_valid = 0; fma_rd = 0; fma_data = 0;
        div_valid = 0; div_rd = 0; div_data = 0;
    endtask

    initial begin
        idle_all();
        rst_n = 0;
        // Reset with every input active
        issue_valid = 1; issue_wr = 1; issue_rd = 4;
        fma_valid = 1; fma_rd = 2; fma_data = 32'h1111_1111;
        div_valid = 1; div_rd = 6; div_data = 32'h2222_2222;
        tick();
        chk_en = 1;
        tick();
        check("rst busy", busy, 32'h0);
        check("rst wren", rd_wren, 1'b0);
        check("rst ready", div_ready, 1'b0);
        check("rst addr", rd_addr, 5'd0);
        check("rst data", rd_data, 32'h0);
        idle_all();
        rst_n = 1;
        tick();
        check("post-rst ready", div_ready, 1'b1);

        // RAW hazard through rs3
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        issue_rs1 = 1; issue_rs2 = 2; issue_rs3 = 3;
        tick();
        idle_all();
        check("busy5 set", busy[5], 1'b1);
        issue_valid = 1; issue_rs3 = 5; issue_uses_rs3 = 1;
        fma_valid = 1; fma_rd = 5; fma_data = 32'h3F80_0000;
        #1;
        check("raw stall", issue_stall, 1'b1);
        tick();
        fma_valid = 0;
        check("raw wren", rd_wren, 1'b1);
        check("raw addr", rd_addr, 5'd5);
        check("raw data", rd_data, 32'h3F80_0000);
        check("busy5 clr", busy[5], 1'b0);
        check("raw unstall", issue_stall, 1'b0);
        tick();
        idle_all();

        // FMA and div collide
        fma_valid = 1; fma_rd = 3; fma_data = 32'hAAAA_0003;
        div_valid = 1; div_rd = 7; div_data = 32'hBBBB_0007;
        tick();
        idle_all();
        check("col f3", rd_addr, 5'd3);
        check("col ready", div_ready, 1'b1);
        tick();
        check("col f7 wren", rd_wren, 1'b1);
        check("col f7 addr", rd_addr, 5'd7);
        check("col f7 data", rd_data, 32'hBBBB_0007);
        tick();
        check("col idle", rd_wren, 1'b0);

        // Fill FIFO under continuous FMA, starve, then drain
        fma_valid = 1; fma_rd = 1; fma_data = 32'h0000_0F0F;
        div_valid = 1; div_rd = 7; div_data = 32'h7777_0000;
        tick();
        div_rd = 9; div_data = 32'h9999_0000;
        tick();
        check("full ready", div_ready, 1'b0);
        div_rd = 11; div_data = 32'hDEAD_0011;
        tick(); tick(); tick();
        check("starve stall", issue_stall, 1'b1);
        fma_data = 32'h0000_1234;
        tick();
        check("sat fma wins", rd_addr, 5'd1);
        check("sat fma data", rd_data, 32'h0000_1234);
        check("sat stall", issue_stall, 1'b1);
        idle_all();
        tick();
        check("drain f7", rd_addr, 5'd7);
        check("drain unstall", issue_stall, 1'b0);
        tick();
        check("drain f9", rd_addr, 5'd9);
        check("drain f9 data", rd_data, 32'h9999_0000);
        tick();
        check("drain done", rd_wren, 1'b0);

        // Pointer wrap with overlapping push/pop
        for (int i = 0; i < 3; i++) begin
            div_valid = 1; div_rd = 5'(16 + i); div_data = 32'(100 + i);
            tick();
            div_rd = 5'(20 + i); div_data = 32'(200 + i);
            tick();
            check("wrap a", rd_addr, 32'(16 + i));
            check("wrap a data", rd_data, 32'(100 + i));
            div_valid = 0;
            tick();
            check("wrap b", rd_addr, 32'(20 + i));
            check("wrap b data", rd_data, 32'(200 + i));
        end
        tick();

        // f0 handling
        issue_valid = 1; issue_wr = 1; issue_rd = 0;
        #1;
        check("f0 no stall", issue_stall, 1'b0);
        tick();
        idle_all();
        check("f0 busy", busy, 32'h0);
        fma_valid = 1; fma_rd = 0; fma_data = 32'h5555_5555;
        tick();
        idle_all();
        check("f0 fma wren", rd_wren, 1'b0);
        div_valid = 1; div_rd = 0; div_data = 32'h6666_6666;
        tick();
        idle_all();
        tick();
        check("f0 div wren", rd_wren, 1'b0);
        tick();
        check("f0 div popped", div_ready, 1'b1);

        // Reset mid-operation
        issue_valid = 1; issue_wr = 1; issue_rd = 9;
        tick();
        idle_all();
        check("mid busy9", busy[9], 1'b1);
        fma_valid = 1; fma_rd = 2; fma_data = 32'h0000_0002;
        div_valid = 1; div_rd = 9; div_data = 32'h9090_9090;
        tick();
        idle_all();
        rst_n = 0;
        tick();
        check("mid rst busy", busy, 32'h0);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid no f9", rd_wren, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Write-back arbiter and scoreboard directly upstream of the floating-point register file; drives that file's single write port (wren/addr/data).
- Merges results from two sources:
  - the pipelined FMA/ALU result path, which has no backpressure;
  - the long-latency div/sqrt unit, which is buffered in a small FIFO.
- Keeps a 32-bit busy scoreboard of pending f-register writes and stalls issue on RAW/WAW hazards, including rs3 for fused ops.

Parameters:
- DEPTH, 2, div/sqrt result FIFO entries (power of two, >=2)
- STARVE_MAX, 4, consecutive cycles the FIFO head may lose arbitration before issue is stalled to drain FMA

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_issue_valid  in  1  FP instruction issuing this cycle
- i_issue_wr  in  1  instruction writes an f-register
- i_issue_rd_addr  in  5  destination f-register
- i_issue_rs1_addr  in  5  source 1
- i_issue_rs2_addr  in  5  source 2
- i_issue_rs3_addr  in  5  source 3
- i_issue_uses_rs3  in  1  rs3 is a real operand (fused multiply-add)
- o_issue_stall  out  1  combinational; issue must hold
- i_fma_valid  in  1  FMA result valid; must be accepted this cycle
- i_fma_rd_addr  in  5  FMA result destination
- i_fma_data  in  32  FMA result
- i_div_valid  in  1  div/sqrt result offered
- i_div_rd_addr  in  5  div/sqrt destination
- i_div_data  in  32  div/sqrt result
- o_div_ready  out  1  FIFO can accept; handshake = valid & ready
- o_rd_wren  out  1  register-file write enable (registered)
- o_rd_addr  out  5  register-file write address (registered)
- o_rd_data  out  32  register-file write data (registered)
- o_busy  out  32  scoreboard vector; bit n = write to fn pending

Behaviour:
- Synchronous reset (i_rst_n=0 at a rising edge):
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_busy=0.
  - FIFO emptied; starve counter=0.
  - o_div_ready=0 while i_rst_n=0.
  - Reset mid-operation drops all buffered and pending results.
- Issue acceptance: accept = i_issue_valid & !o_issue_stall.
- o_issue_stall=1 when any of the following hold:
  - busy[rs1] or busy[rs2];
  - i_issue_uses_rs3 & busy[rs3];
  - i_issue_wr & busy[rd] (WAW);
  - starve counter == STARVE_MAX.
  - Stall is evaluated from the registered busy vector only.
- Scoreboard set: on accept with i_issue_wr and rd!=0, busy[rd]<=1 at the next edge.
- Scoreboard clear: busy[addr]<=0 at the edge where o_rd_wren/o_rd_addr are loaded with that address.
- Same-bit set and clear in one cycle cannot occur (WAW stall); if forced, clear wins.
- busy[0] is always 0, because f0 is hardwired zero in the register file.
- Arbitration, each cycle, fixed priority:
  1. i_fma_valid;
  2. else FIFO head, which is popped;
  3. else nothing.
- The winner is registered into o_rd_wren/addr/data, so write-back latency is 1 cycle from the input.
- The register file captures the write on the following falling edge.
- A winner with rd_addr==0 is still consumed/popped, but o_rd_wren=0.
- On idle cycles o_rd_wren=0 and addr/data hold their last values.
- FIFO:
  - o_div_ready = !full & i_rst_n.
  - Push on i_div_valid & o_div_ready.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - A push into an empty FIFO cannot be popped in the same cycle, so minimum div latency is 2 cycles.
- Starve counter:
  - Increments when the FIFO is non-empty and FMA wins.
  - Resets to 0 on a pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - At STARVE_MAX, o_issue_stall=1 so the FMA pipeline drains and the FIFO wins.
- FMA results are never dropped; a FMA result arriving while the counter is saturated still wins.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with all inputs active -> o_busy=0, o_rd_wren=0, o_div_ready=0; 1 cycle after release, o_div_ready=1.
- RAW hazard:
  - issue rd=5, wr=1 -> o_busy[5]=1 next cycle;
  - then issue rs3=5, uses_rs3=1 -> stall=1;
  - i_fma_valid rd=5 data=0x3F800000 -> next cycle o_rd_wren=1, addr=5, data=0x3F800000, busy[5]=0;
  - stall drops the same cycle.
- Collision: FMA rd=3 and div rd=7 valid in the same cycle:
  - cycle+1: write f3;
  - cycle+2: write f7 from the FIFO;
  - o_div_ready stays 1 (DEPTH=2).
- FIFO full/wrap: FMA valid continuously while 2 div results are pushed -> o_div_ready=0. Then:
  - starve counter reaches 4 -> o_issue_stall=1;
  - once FMA idles, the FIFO drains in order f7, f9;
  - 3 more push/pop rounds verify pointer wrap.
- f0 handling:
  - issue rd=0 -> busy stays 0, no stall;
  - FMA result rd=0 -> o_rd_wren=0 and it is consumed;
  - div result rd=0 -> popped with o_rd_wren=0.
- Reset mid-operation: FIFO holding 1 entry with busy[9]=1, assert reset -> FIFO empty, busy=0, and no write to f9 after release.
